// File: rtl/prim_unpacker_pkg.sv
// Shared types for the word-to-chunk unpacker.
// Holds only the FSM state encoding used by prim_unpacker.
package prim_unpacker_pkg;

    typedef enum logic [0:0] {
        StEmpty,
        StDrain
    } unpack_st_e;

endpackage

// File: rtl/prim_popcount.sv
// Population count of a Width-bit vector.
// The result is sized to hold Width itself.
module prim_popcount #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0]             in_i,
    output logic [$clog2(Width+1)-1:0]   cnt_o
);

    localparam int unsigned CntW = $clog2(Width + 1);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < Width; i++) begin
            cnt_o = cnt_o + CntW'(in_i[i]);
        end
    end

endmodule

// File: rtl/prim_unpacker.sv
// Splits one InW-bit word into OutW-bit chunks, LSB first, emitting only
// as many chunks as the contiguous input mask covers.
module prim_unpacker
    import prim_unpacker_pkg::*;
#(
    parameter int unsigned InW  = 32,
    parameter int unsigned OutW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [InW-1:0]  data_i,
    input  logic [InW-1:0]  mask_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [OutW-1:0] data_o,
    output logic [OutW-1:0] mask_o,
    output logic            last_o,
    input  logic            ready_i,
    input  logic            flush_i,
    output logic            flush_done_o
);

    localparam int unsigned RemW = $clog2(InW + 1);

    if ((InW < OutW) || ((InW % OutW) != 0)) begin : gen_param_check
        $error("prim_unpacker: InW must be a multiple of OutW and >= OutW");
    end

    unpack_st_e     state_q, state_d;
    logic [InW-1:0] data_q, data_d;
    logic [RemW-1:0] rem_q, rem_d;
    logic [RemW-1:0] mask_cnt;
    logic           flush_done_q, flush_done_d;
    logic           ack_in, ack_out;

    prim_popcount #(
        .Width (InW)
    ) u_mask_cnt (
        .in_i  (mask_i),
        .cnt_o (mask_cnt)
    );

    always_comb begin
        valid_o = (state_q == StDrain);
        mask_o  = '0;
        for (int i = 0; i < OutW; i++) begin
            mask_o[i] = (rem_q > RemW'(i));
        end
        data_o  = data_q[OutW-1:0] & mask_o;
        last_o  = valid_o & (rem_q <= RemW'(OutW));
        // ready_i -> ready_o is combinational so a new word lands on the last beat.
        ready_o = !flush_i & ((state_q == StEmpty) | (last_o & ready_i));
        ack_in  = valid_i & ready_o;
        ack_out = valid_o & ready_i;
        flush_done_o = flush_done_q;
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        rem_d        = rem_q;
        flush_done_d = flush_i;
        if (flush_i) begin
            state_d = StEmpty;
            data_d  = '0;
            rem_d   = '0;
        end else begin
            if (ack_out) begin
                if (last_o) begin
                    state_d = StEmpty;
                    data_d  = '0;
                    rem_d   = '0;
                end else begin
                    data_d = data_q >> OutW;
                    rem_d  = rem_q - RemW'(OutW);
                end
            end
            if (ack_in) begin
                data_d  = data_i;
                rem_d   = mask_cnt;
                state_d = (mask_cnt == '0) ? StEmpty : StDrain;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StEmpty;
            data_q       <= '0;
            rem_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            rem_q        <= rem_d;
            flush_done_q <= flush_done_d;
        end
    end

    a_mask_contig: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_i |-> ((mask_i & (mask_i + InW'(1))) == '0));

    a_no_flush_with_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(flush_i && valid_i));

    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !flush_i) |=>
            ($stable(data_o) && $stable(mask_o) && $stable(last_o) && valid_o));

    a_rem_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rem_q <= RemW'(InW));

endmodule

// File: tb/tb_prim_unpacker.sv
// Directed bench for prim_unpacker at InW=32, OutW=8.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_prim_unpacker;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [31:0] data_i;
    logic [31:0] mask_i;
    logic        ready_o;
    logic        valid_o;
    logic [7:0]  data_o;
    logic [7:0]  mask_o;
    logic        last_o;
    logic        ready_i;
    logic        flush_i;
    logic        flush_done_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    prim_unpacker #(
        .InW  (32),
        .OutW (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .mask_i       (mask_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .mask_o       (mask_o),
        .last_o       (last_o),
        .ready_i      (ready_i),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o)
    );

    task automatic test_reset();
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        mask_i  = '0;
        ready_i = 1'b0;
        flush_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        total++;
        if ({valid_o, last_o, mask_o, data_o, flush_done_o, ready_o} !== {20'h0, 1'b0, 1'b1}) begin
            $display("FAIL reset_outputs: got v=%b l=%b m=%h d=%h fd=%b r=%b, want 0 0 00 00 0 1",
                     valid_o, last_o, mask_o, data_o, flush_done_o, ready_o);
            bad++;
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_full_word();
        logic [31:0] w;
        logic [17:0] exp_v;
        w = 32'hDDCCBBAA;
        @(negedge clk_i);
        valid_i = 1'b1; data_i = w; mask_i = 32'hFFFF_FFFF; ready_i = 1'b1;
        #1;
        total++;
        if ({ready_o, valid_o} !== 2'b10) begin
            $display("FAIL full_accept: got ready=%b valid=%b, want 1 0", ready_o, valid_o);
            bad++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            valid_i = 1'b0;
            #1;
            exp_v = {1'b1, w[8*k +: 8], 8'hFF, (k == 3)};
            total++;
            if ({valid_o, data_o, mask_o, last_o} !== exp_v) begin
                $display("FAIL full_beat%0d: got v=%b d=%h m=%h l=%b, want %h", k,
                         valid_o, data_o, mask_o, last_o, exp_v);
                bad++;
            end
        end
        @(negedge clk_i);
        #1;
        total++;
        if ({valid_o, ready_o} !== 2'b01) begin
            $display("FAIL full_end: got valid=%b ready=%b, want 0 1", valid_o, ready_o);
            bad++;
        end
    endtask

    task automatic test_partial();
        logic [7:0]  exp_d [3];
        logic [7:0]  exp_m [3];
        logic [17:0] exp_v;
        exp_d[0] = 8'hAA; exp_d[1] = 8'hBB; exp_d[2] = 8'h0C;
        exp_m[0] = 8'hFF; exp_m[1] = 8'hFF; exp_m[2] = 8'h0F;
        @(negedge clk_i);
        valid_i = 1'b1; data_i = 32'h000CBBAA; mask_i = 32'h000F_FFFF; ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            valid_i = 1'b0;
            #1;
            exp_v = {1'b1, exp_d[k], exp_m[k], (k == 2)};
            total++;
            if ({valid_o, data_o, mask_o, last_o} !== exp_v) begin
                $display("FAIL partial_beat%0d: got v=%b d=%h m=%h l=%b, want %h", k,
                         valid_o, data_o, mask_o, last_o, exp_v);
                bad++;
            end
        end
        @(negedge clk_i);
        #1;
        total++;
        if (valid_o !== 1'b0) begin
            $display("FAIL partial_end: got valid=%b, want 0", valid_o);
            bad++;
        end
    endtask

    task automatic test_zero_mask();
        @(negedge clk_i);
        valid_i = 1'b1; data_i = 32'h12345678; mask_i = '0; ready_i = 1'b1;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            $display("FAIL zero_accept: got ready=%b, want 1", ready_o);
            bad++;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            valid_i = 1'b0;
            #1;
            total++;
            if ({valid_o, ready_o, mask_o} !== {1'b0, 1'b1, 8'h00}) begin
                $display("FAIL zero_idle%0d: got v=%b r=%b m=%h, want 0 1 00", k,
                         valid_o, ready_o, mask_o);
                bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] both;
        logic [17:0] exp_v;
        both = 64'h88776655_44332211;
        @(negedge clk_i);
        valid_i = 1'b1; data_i = both[31:0]; mask_i = 32'hFFFF_FFFF; ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            valid_i = (k == 3);
            data_i  = both[63:32];
            #1;
            exp_v = {1'b1, both[8*k +: 8], 8'hFF, (k == 3 || k == 7)};
            total++;
            if ({valid_o, data_o, mask_o, last_o} !== exp_v) begin
                $display("FAIL b2b_beat%0d: got v=%b d=%h m=%h l=%b, want %h", k,
                         valid_o, data_o, mask_o, last_o, exp_v);
                bad++;
            end
            if (k == 3) begin
                total++;
                if (ready_o !== 1'b1) begin
                    $display("FAIL b2b_same_cycle_ready: got %b, want 1", ready_o);
                    bad++;
                end
            end
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        total++;
        if (valid_o !== 1'b0) begin
            $display("FAIL b2b_end: got valid=%b, want 0", valid_o);
            bad++;
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] exp_v;
        logic [31:0] w;
        w = 32'hDDCCBBAA;
        @(negedge clk_i);
        valid_i = 1'b1; data_i = w; mask_i = 32'hFFFF_FFFF; ready_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        total++;
        if ({valid_o, data_o} !== {1'b1, 8'hAA}) begin
            $display("FAIL bp_first: got v=%b d=%h, want 1 aa", valid_o, data_o);
            bad++;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            ready_i = 1'b0;
            #1;
            total++;
            if ({valid_o, data_o, mask_o, last_o, ready_o} !== {1'b1, 8'hBB, 8'hFF, 2'b00}) begin
                $display("FAIL bp_hold%0d: got v=%b d=%h m=%h l=%b r=%b, want 1 bb ff 0 0", k,
                         valid_o, data_o, mask_o, last_o, ready_o);
                bad++;
            end
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk_i);
            ready_i = 1'b1;
            #1;
            exp_v = {1'b1, w[8*k +: 8], 8'hFF, (k == 3)};
            total++;
            if ({valid_o, data_o, mask_o, last_o} !== exp_v) begin
                $display("FAIL bp_resume%0d: got v=%b d=%h m=%h l=%b, want %h", k,
                         valid_o, data_o, mask_o, last_o, exp_v);
                bad++;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_flush_and_reset();
        @(negedge clk_i);
        valid_i = 1'b1; data_i = 32'hDDCCBBAA; mask_i = 32'hFFFF_FFFF; ready_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        total++;
        if ({valid_o, data_o} !== {1'b1, 8'hAA}) begin
            $display("FAIL flush_first: got v=%b d=%h, want 1 aa", valid_o, data_o);
            bad++;
        end
        @(negedge clk_i);
        ready_i = 1'b0; flush_i = 1'b1;
        #1;
        total++;
        if ({valid_o, data_o, ready_o} !== {1'b1, 8'hBB, 1'b0}) begin
            $display("FAIL flush_cycle: got v=%b d=%h r=%b, want 1 bb 0", valid_o, data_o, ready_o);
            bad++;
        end
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        total++;
        if ({valid_o, flush_done_o, ready_o, mask_o, data_o} !== {3'b011, 16'h0}) begin
            $display("FAIL flush_after: got v=%b fd=%b r=%b m=%h d=%h, want 0 1 1 00 00",
                     valid_o, flush_done_o, ready_o, mask_o, data_o);
            bad++;
        end
        @(negedge clk_i);
        #1;
        total++;
        if (flush_done_o !== 1'b0) begin
            $display("FAIL flush_pulse_width: got fd=%b, want 0", flush_done_o);
            bad++;
        end
        // Flush while already empty still produces the pulse.
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        total++;
        if ({flush_done_o, valid_o, ready_o} !== 3'b101) begin
            $display("FAIL flush_empty: got fd=%b v=%b r=%b, want 1 0 1",
                     flush_done_o, valid_o, ready_o);
            bad++;
        end
        @(negedge clk_i);
        valid_i = 1'b1; data_i = 32'hDDCCBBAA; mask_i = 32'hFFFF_FFFF; ready_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0; ready_i = 1'b0;
        #1;
        total++;
        if ({valid_o, data_o} !== {1'b1, 8'hAA}) begin
            $display("FAIL rst_pre: got v=%b d=%h, want 1 aa", valid_o, data_o);
            bad++;
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        total++;
        if ({valid_o, last_o, mask_o, data_o, flush_done_o, ready_o} !== {20'h0, 1'b0, 1'b1}) begin
            $display("FAIL rst_mid_drain: got v=%b l=%b m=%h d=%h fd=%b r=%b, want 0 0 00 00 0 1",
                     valid_o, last_o, mask_o, data_o, flush_done_o, ready_o);
            bad++;
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        total++;
        if ({valid_o, flush_done_o, ready_o} !== 3'b001) begin
            $display("FAIL rst_release: got v=%b fd=%b r=%b, want 0 0 1",
                     valid_o, flush_done_o, ready_o);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_zero_mask();
        test_back_to_back();
        test_backpressure();
        test_flush_and_reset();
        repeat (2) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
